// File: rtl/uart_tx_byte_writer_if.sv
// rtl/uart_tx_byte_writer_if.sv - wishbone bus bundle between the byte writer and the UART mux
//
// Signals: adr, dat_o (master->slave write data), dat_i (slave->master read
// data), sel, we, cyc, stb, ack. The master modport is used by the byte
// writer; the slave modport is used by the mux port or a bus model.

interface uart_tx_byte_writer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   adr;
   logic [DATA_W-1:0]   dat_o;
   logic [DATA_W-1:0]   dat_i;
   logic [DATA_W/8-1:0] sel;
   logic                we;
   logic                cyc;
   logic                stb;
   logic                ack;

   modport master (output adr, dat_o, sel, we, cyc, stb, input dat_i, ack);
   modport slave  (input adr, dat_o, sel, we, cyc, stb, output dat_i, ack);
endinterface

// File: rtl/uart_tx_byte_writer.sv
// rtl/uart_tx_byte_writer.sv - writes a byte stream into a 16550 THR, polling LSR.THRE per burst
//
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   wb_master       wishbone master towards the UART mux port
//   in_valid/in_data/in_ready  byte input handshake (in_ready only in IDLE)
//   busy            high whenever the FSM is outside IDLE
//   timeout_err     sticky ack-timeout flag, cleared by err_clr (set wins)
//
// One LSR read with THRE set grants BURST_LEN THR writes (the depth of the
// UART TX FIFO); credit only refills from a fresh poll after it drains.

module uart_tx_byte_writer #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int THR_ADDR    = 0,
   parameter int LSR_ADDR    = 5,
   parameter int THRE_BIT    = 5,
   parameter int BURST_LEN   = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   uart_tx_byte_writer_if.master wb_master,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  busy,
   output logic                  timeout_err,
   input  logic                  err_clr
);
   localparam int SW = DATA_W / 8;
   localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] THR_A   = ADDR_W'(THR_ADDR);
   localparam logic [ADDR_W-1:0] LSR_A   = ADDR_W'(LSR_ADDR);
   localparam logic [SW-1:0]     THR_SEL = SW'(1) << (THR_ADDR % 4);
   localparam logic [SW-1:0]     LSR_SEL = SW'(1) << (LSR_ADDR % 4);

   typedef enum logic [1:0] {IDLE, LSR_RD, POLL_GAP, THR_WR} state_t;

   state_t        state;
   logic [4:0]    credit;
   logic [7:0]    byte_q;
   logic [TW-1:0] tmo_cnt;
   logic          rst_done;
   logic [7:0]    rd_lane;
   logic          tmo_hit;

   // Read data comes from the byte lane addressed by adr[1:0].
   assign rd_lane  = wb_master.dat_i[{wb_master.adr[1:0], 3'b000} +: 8];
   assign tmo_hit  = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
   // rst_done keeps in_ready low while rstn is asserted even though the
   // state register already sits in IDLE.
   assign in_ready = rst_done && (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= IDLE;
         rst_done        <= 1'b0;
         credit          <= '0;
         byte_q          <= '0;
         tmo_cnt         <= '0;
         timeout_err     <= 1'b0;
         wb_master.cyc   <= 1'b0;
         wb_master.stb   <= 1'b0;
         wb_master.we    <= 1'b0;
         wb_master.adr   <= '0;
         wb_master.dat_o <= '0;
         wb_master.sel   <= '0;
      end else begin
         rst_done <= 1'b1;
         if (err_clr) begin
            timeout_err <= 1'b0;
         end

         if (wb_master.cyc && !wb_master.ack && tmo_hit) begin
            // Abort: the byte is dropped and the FIFO state is unknown, so
            // credit is zeroed to force a fresh LSR poll.
            wb_master.cyc <= 1'b0;
            wb_master.stb <= 1'b0;
            wb_master.we  <= 1'b0;
            timeout_err   <= 1'b1;
            credit        <= '0;
            state         <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (in_ready && in_valid) begin
                     byte_q        <= in_data;
                     tmo_cnt       <= '0;
                     wb_master.cyc <= 1'b1;
                     wb_master.stb <= 1'b1;
                     if (credit != 5'd0) begin
                        state           <= THR_WR;
                        wb_master.we    <= 1'b1;
                        wb_master.adr   <= THR_A;
                        wb_master.sel   <= THR_SEL;
                        wb_master.dat_o <= {SW{in_data}};
                     end else begin
                        state         <= LSR_RD;
                        wb_master.we  <= 1'b0;
                        wb_master.adr <= LSR_A;
                        wb_master.sel <= LSR_SEL;
                     end
                  end
               end
               LSR_RD: begin
                  if (wb_master.cyc && wb_master.ack) begin
                     wb_master.cyc <= 1'b0;
                     wb_master.stb <= 1'b0;
                     if (rd_lane[THRE_BIT]) begin
                        credit <= 5'(BURST_LEN);
                        state  <= THR_WR;
                     end else begin
                        state <= POLL_GAP;
                     end
                  end else if (wb_master.cyc) begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
               POLL_GAP: begin
                  state         <= LSR_RD;
                  tmo_cnt       <= '0;
                  wb_master.cyc <= 1'b1;
                  wb_master.stb <= 1'b1;
                  wb_master.we  <= 1'b0;
                  wb_master.adr <= LSR_A;
                  wb_master.sel <= LSR_SEL;
               end
               THR_WR: begin
                  if (!wb_master.cyc) begin
                     // Entered from a successful poll: the read cycle was
                     // closed on its ack, so the write opens here.
                     tmo_cnt         <= '0;
                     wb_master.cyc   <= 1'b1;
                     wb_master.stb   <= 1'b1;
                     wb_master.we    <= 1'b1;
                     wb_master.adr   <= THR_A;
                     wb_master.sel   <= THR_SEL;
                     wb_master.dat_o <= {SW{byte_q}};
                  end else if (wb_master.ack) begin
                     wb_master.cyc <= 1'b0;
                     wb_master.stb <= 1'b0;
                     wb_master.we  <= 1'b0;
                     if (credit != 5'd0) begin
                        credit <= credit - 5'd1;
                     end
                     state <= IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_byte_writer.sv
// tb/tb_uart_tx_byte_writer.sv - self-checking bench for uart_tx_byte_writer

module tb_uart_tx_byte_writer;
   localparam int BURST = 16;

   typedef struct {
      logic        we;
      logic [4:0]  adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          cyc;
   } txn_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       busy;
   logic       timeout_err;
   logic       err_clr;
   logic       ack_on;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc_n = 0;
   int   lsr_idx = 0;
   int   m_idx = 0;
   int   m_credit = 0;
   logic [7:0] lsr_mem [0:1023];
   txn_t got[$];
   txn_t exp_q[$];

   uart_tx_byte_writer_if #(.ADDR_W(5), .DATA_W(32)) wb ();

   uart_tx_byte_writer dut (
      .clk         (clk),
      .rstn        (rstn),
      .wb_master   (wb),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   // Bus slave: zero-wait ack; LSR byte lives on lane 1, other lanes carry
   // its complement so a wrong-lane read sees the opposite THRE value.
   assign wb.ack   = wb.cyc & wb.stb & ack_on;
   assign wb.dat_i = {~lsr_mem[lsr_idx], ~lsr_mem[lsr_idx], lsr_mem[lsr_idx], ~lsr_mem[lsr_idx]};

   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      if (rstn && wb.cyc && wb.stb && wb.ack && !wb.we) lsr_idx <= lsr_idx + 1;
   end

   always @(negedge clk) begin
      if (rstn && wb.cyc && wb.stb && wb.ack)
         got.push_back('{wb.we, wb.adr, wb.sel, wb.dat_o, cyc_n});
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   // Reference: each byte first needs credit; with none, LSR is read until
   // THRE appears, which grants a full burst.
   task automatic model_byte(input logic [7:0] b);
      logic [7:0] v;
      if (m_credit == 0) begin
         do begin
            v = lsr_mem[m_idx];
            m_idx++;
            exp_q.push_back('{1'b0, 5'd5, 4'b0010, 32'h0, 0});
         end while (!v[5]);
         m_credit = BURST;
      end
      exp_q.push_back('{1'b1, 5'd0, 4'b0001, {4{b}}, 0});
      m_credit--;
   endtask

   task automatic compare(input string tag);
      chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got.size()) begin
            chk($sformatf("%s_we%0d", tag, i), 32'(got[i].we), 32'(exp_q[i].we));
            chk($sformatf("%s_adr%0d", tag, i), 32'(got[i].adr), 32'(exp_q[i].adr));
            chk($sformatf("%s_sel%0d", tag, i), 32'(got[i].sel), 32'(exp_q[i].sel));
            if (exp_q[i].we) chk($sformatf("%s_dat%0d", tag, i), got[i].dat, exp_q[i].dat);
         end
      end
   endtask

   task automatic clear_q();
      got.delete();
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      while (!in_ready && k < 600) begin
         @(negedge clk);
         k++;
      end
      if (k >= 600) chk("send_wait", 32'(k), 32'(0));
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((busy || !in_ready) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) chk({tag, "_idle_wait"}, 32'(k), 32'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      m_credit = 0;
   endtask

   initial begin
      int n;
      int k;
      for (int i = 0; i < 1024; i++) lsr_mem[i] = 8'h20;
      rstn = 1'b0; in_valid = 1'b1; in_data = 8'h55; err_clr = 1'b0; ack_on = 1'b1;

      // Reset with input offered.
      repeat (3) @(negedge clk);
      chk("rst_cyc", 32'(wb.cyc), 32'(0));
      chk("rst_stb", 32'(wb.stb), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_timeout_err", 32'(timeout_err), 32'(0));
      in_valid = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", 32'(in_ready), 32'(1));
      chk("rel_count", 32'(got.size()), 32'(0));

      // Single byte, LSR 0x60.
      lsr_mem[m_idx] = 8'h60;
      send_byte(8'h41); model_byte(8'h41);
      wait_idle("single");
      compare("single");
      clear_q();

      // THRE low twice.
      do_reset();
      lsr_mem[m_idx] = 8'h00; lsr_mem[m_idx + 1] = 8'h00; lsr_mem[m_idx + 2] = 8'h20;
      send_byte(8'hA5); model_byte(8'hA5);
      wait_idle("poll");
      compare("poll");
      if (got.size() >= 3) begin
         chk("poll_gap1", 32'(got[1].cyc - got[0].cyc), 32'(2));
         chk("poll_gap2", 32'(got[2].cyc - got[1].cyc), 32'(2));
      end
      clear_q();

      // 17-byte stream across a burst boundary.
      do_reset();
      lsr_mem[m_idx] = 8'h20; lsr_mem[m_idx + 1] = 8'h20;
      for (int i = 0; i <= 16; i++) begin
         send_byte(8'(i)); model_byte(8'(i));
      end
      wait_idle("burst");
      compare("burst");
      if (got.size() >= 19) begin
         for (int i = 0; i < 15; i++)
            chk($sformatf("burst_spacing%0d", i), 32'(got[i + 2].cyc - got[i + 1].cyc), 32'(2));
      end
      clear_q();

      // THR write never acked.
      ack_on = 1'b0;
      send_byte(8'h77);
      n = 0; k = 0;
      while (k < 1000 && !(n > 0 && !wb.cyc)) begin
         if (wb.cyc) n++;
         @(negedge clk);
         k++;
      end
      chk("tmo_cycles", 32'(n), 32'(255));
      chk("tmo_err", 32'(timeout_err), 32'(1));
      chk("tmo_in_ready", 32'(in_ready), 32'(1));
      chk("tmo_count", 32'(got.size()), 32'(0));
      m_credit = 0;
      ack_on = 1'b1;
      send_byte(8'h3C); model_byte(8'h3C);
      wait_idle("after_tmo");
      compare("after_tmo");
      clear_q();
      chk("tmo_sticky", 32'(timeout_err), 32'(1));
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr", 32'(timeout_err), 32'(0));

      // Reset while a THR write is pending.
      ack_on = 1'b0;
      send_byte(8'h99);
      repeat (5) @(negedge clk);
      chk("pend_cyc", 32'(wb.cyc), 32'(1));
      rstn = 1'b0;
      @(negedge clk);
      chk("midrst_cyc", 32'(wb.cyc), 32'(0));
      chk("midrst_stb", 32'(wb.stb), 32'(0));
      rstn = 1'b1;
      ack_on = 1'b1;
      m_credit = 0;
      clear_q();
      send_byte(8'hC3); model_byte(8'hC3);
      wait_idle("midrst");
      compare("midrst");
      clear_q();

      // Randomized bytes, LSR values and idle gaps.
      for (int i = 0; i < 200; i++) lsr_mem[m_idx + i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         send_byte(b); model_byte(b);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("rand");
      compare("rand");
      chk("rand_err", 32'(timeout_err), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_tx_byte_writer.md
Name: uart_tx_byte_writer

Overview:
- Wishbone master engine that takes a byte stream over a valid/ready handshake and writes it into the 16550-style UART transmit holding register (THR).
- Before each burst it polls the line status register (LSR) for THRE (transmitter holding register empty). Once THRE is seen, it writes up to BURST_LEN bytes back-to-back into the UART TX FIFO without re-polling.
- Sits in the UART gateway as an additional wishbone source on a mux slave port, upstream of the mux and the UART IP. It is fed by the handshake/xmodem payload logic.

Parameters:
- ADDR_W, 5, wishbone address width (matches UART address width)
- DATA_W, 32, wishbone data width
- THR_ADDR, 0, byte address of THR
- LSR_ADDR, 5, byte address of LSR
- THRE_BIT, 5, LSR bit index of THRE
- BURST_LEN, 16, bytes written per THRE observation (UART TX FIFO depth), range 1..16
- ACK_TIMEOUT, 255, cycles to wait for ack before aborting a transaction

Ports:
- clk, input, 1, clock
- rstn, input, 1, synchronous active-low reset
- wb_master, modport wishbone.master, ADDR_W/DATA_W/4, wishbone master. Uses adr, dat_o, dat_i, sel, we, cyc, stb, ack.
- in_valid, input, 1, byte available
- in_data, input, 8, byte to transmit
- in_ready, output, 1, byte accepted when in_valid && in_ready
- busy, output, 1, high in any state other than IDLE
- timeout_err, output, 1, sticky error flag, set on ack timeout
- err_clr, input, 1, clears timeout_err

Behaviour:
- Reset: all state in this block, including the FSM, is updated only on posedge clk.
  - While rstn=0 at a clock edge, the block enters IDLE.
  - cyc, stb, we drive 0; adr drives 0; dat_o drives 0; sel drives 0.
  - in_ready=0, busy=0, timeout_err=0.
  - Burst credit is 0 and the byte register is cleared.
  - Reset mid-transaction drops cyc/stb at that edge; a partially accepted byte is discarded.
- Byte lane:
  - sel = 4'b0001 << adr[1:0].
  - Write data is replicated on all four byte lanes.
  - Read data is taken from the lane adr[1:0].
- FSM states:
  - IDLE:
    - in_ready=1.
    - On handshake, capture in_data.
    - If credit>0, go to THR_WR; otherwise go to LSR_RD.
  - LSR_RD:
    - cyc=stb=1, we=0, adr=LSR_ADDR.
    - Hold until ack.
    - On ack, drop cyc/stb in the same cycle the ack is sampled.
    - If dat_i lane bit THRE_BIT=1: credit=BURST_LEN, go to THR_WR.
    - Otherwise go to POLL_GAP.
  - POLL_GAP: exactly one idle cycle (cyc=0), then go to LSR_RD.
  - THR_WR:
    - cyc=stb=1, we=1, adr=THR_ADDR, dat_o lanes = captured byte.
    - Hold until ack.
    - On ack: credit decrements by 1 and the FSM returns to IDLE.
- Handshake timing:
  - in_ready is combinationally tied to state==IDLE.
  - At most one byte is held at a time; no new byte is accepted before the previous THR ack.
- Latency:
  - With credit>0 and 1-cycle ack, handshake to THR cyc is 1 cycle and the THR cycle lasts 1 cycle.
  - Sustained throughput is therefore 1 byte per 2 cycles within a burst.
- Credit:
  - 5-bit counter that never underflows.
  - Credit is not replenished mid-burst.
  - When credit reaches 0, the next byte forces an LSR poll.
- Timeout:
  - A counter runs while cyc=1 and ack=0.
  - If it reaches ACK_TIMEOUT: drop cyc/stb, set timeout_err, set credit=0, discard the byte, go to IDLE.
  - The counter clears on every new transaction.
- err_clr: clears timeout_err on the next edge. If err_clr and a new timeout occur in the same cycle, set wins.
- Ack outside LSR_RD/THR_WR, or while cyc=0, is ignored.
- in_valid while not in IDLE is ignored; in_data need not be held stable once accepted.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with in_valid=1 -> cyc=stb=0, in_ready=0, busy=0, timeout_err=0. First edge with rstn=1 -> in_ready=1.
- Single byte, LSR returns 0x60 -> one read at adr 5 (sel=4'b0010), then one write at adr 0 (sel=4'b0001, dat_o=0x41414141 for byte 0x41). Back to IDLE, credit=15.
- THRE low twice (LSR=0x00, 0x00, then 0x20) -> three LSR reads, each separated by exactly one cyc=0 cycle, then a THR write.
- BURST_LEN=16 stream of 17 bytes 0x00..0x10 with 1-cycle ack -> one LSR read, 16 THR writes 2 cycles apart, a second LSR read before byte 0x10.
- Slave never acks during THR write, ACK_TIMEOUT=255 -> cyc drops after 255 cycles, timeout_err=1, in_ready=1. Next byte triggers an LSR read. err_clr pulse -> timeout_err=0.
- Reset asserted while THR write is pending without ack -> cyc=0 on that edge; after release, credit=0, so the next byte polls LSR first.
